// File: rtl/seg7_pkg.sv
// Shared types and segment pattern constants for the 7-segment readback path.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    // Active-low patterns, bit order {G,F,E,D,C,B,A}
    localparam seg7_t SEG_0     = 7'h40;
    localparam seg7_t SEG_1     = 7'h79;
    localparam seg7_t SEG_2     = 7'h24;
    localparam seg7_t SEG_3     = 7'h30;
    localparam seg7_t SEG_4     = 7'h19;
    localparam seg7_t SEG_5     = 7'h12;
    localparam seg7_t SEG_6     = 7'h02;
    localparam seg7_t SEG_7     = 7'h78;
    localparam seg7_t SEG_8     = 7'h00;
    localparam seg7_t SEG_9     = 7'h10;
    localparam seg7_t SEG_A     = 7'h08;
    localparam seg7_t SEG_B     = 7'h03;
    localparam seg7_t SEG_C     = 7'h46;
    localparam seg7_t SEG_D     = 7'h21;
    localparam seg7_t SEG_E     = 7'h06;
    localparam seg7_t SEG_F     = 7'h0E;
    localparam seg7_t SEG_BLANK = 7'h7F;

    typedef enum logic {S_TRACK, S_HOLD} cap_state_e;

    typedef struct packed {
        logic [3:0] val;
        logic       blank;
        logic       bad;
    } seg7_dec_t;

endpackage

// File: rtl/seg7_scan_capture_decode.sv
// Combinational segment-pattern to nibble decoder.
// Hex letters A-F are recognised only when SEG7_HEX_EN is defined.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  seg7_t     seg,
    output seg7_dec_t dec
);

    // Pattern lookup; unknown patterns decode as invalid
    always_comb begin
        dec = '{val: 4'hF, blank: 1'b0, bad: 1'b1};
        case (seg)
            SEG_0:     dec = '{val: 4'h0, blank: 1'b0, bad: 1'b0};
            SEG_1:     dec = '{val: 4'h1, blank: 1'b0, bad: 1'b0};
            SEG_2:     dec = '{val: 4'h2, blank: 1'b0, bad: 1'b0};
            SEG_3:     dec = '{val: 4'h3, blank: 1'b0, bad: 1'b0};
            SEG_4:     dec = '{val: 4'h4, blank: 1'b0, bad: 1'b0};
            SEG_5:     dec = '{val: 4'h5, blank: 1'b0, bad: 1'b0};
            SEG_6:     dec = '{val: 4'h6, blank: 1'b0, bad: 1'b0};
            SEG_7:     dec = '{val: 4'h7, blank: 1'b0, bad: 1'b0};
            SEG_8:     dec = '{val: 4'h8, blank: 1'b0, bad: 1'b0};
            SEG_9:     dec = '{val: 4'h9, blank: 1'b0, bad: 1'b0};
            SEG_BLANK: dec = '{val: 4'hF, blank: 1'b1, bad: 1'b0};
`ifdef SEG7_HEX_EN
            SEG_A:     dec = '{val: 4'hA, blank: 1'b0, bad: 1'b0};
            SEG_B:     dec = '{val: 4'hB, blank: 1'b0, bad: 1'b0};
            SEG_C:     dec = '{val: 4'hC, blank: 1'b0, bad: 1'b0};
            SEG_D:     dec = '{val: 4'hD, blank: 1'b0, bad: 1'b0};
            SEG_E:     dec = '{val: 4'hE, blank: 1'b0, bad: 1'b0};
            SEG_F:     dec = '{val: 4'hF, blank: 1'b0, bad: 1'b0};
`endif
            default:   dec = '{val: 4'hF, blank: 1'b0, bad: 1'b1};
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Readback receiver for the multiplexed 7-segment bus: settles, decodes and assembles digit frames.
// Build option SEG7_HEX_EN enables decoding of hex letters A-F (ports unchanged).
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [SW-1:0]         sync_r;
    logic [SW-1:0]         sample_r;
    logic [CW-1:0]         cnt_r;
    cap_state_e            state_r;
    logic [NUM_DIGITS-1:0] seen_r;
    logic                  err_r;
    logic [3:0]            slot_val_r   [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] slot_blank_r;

    logic                  same_s;
    logic                  commit_s;
    logic [NUM_DIGITS-1:0] an_low_s;
    logic                  one_hot_s;
    logic                  multi_s;
    logic [NUM_DIGITS-1:0] wr_mask_s;
    logic                  err_set_s;
    seg7_t                 seg_s;
    seg7_dec_t             dec_s;

    assign seg_s = sample_r[6:0];

    seg7_pattern_decode u_decode (
        .seg (seg_s),
        .dec (dec_s)
    );

    // Two-stage synchronizer and stability counter; the second stage doubles
    // as the previous sample, so a change is seen as soon as stage one differs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r   <= {SW{1'b1}};
            sample_r <= {SW{1'b1}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            sync_r   <= {an_in, seg_in};
            sample_r <= sync_r;
            if (sync_r != sample_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r != CW'(STABLE_CYCLES)) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Commit qualification and anode classification
    always_comb begin
        same_s    = (sync_r == sample_r);
        commit_s  = 1'b0;
        an_low_s  = ~sample_r[SW-1:7];
        one_hot_s = 1'b0;
        multi_s   = 1'b0;
        wr_mask_s = {NUM_DIGITS{1'b0}};
        err_set_s = 1'b0;
        if ((state_r == S_TRACK) && same_s && (cnt_r == CW'(STABLE_CYCLES - 1))) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
        if ((an_low_s & (an_low_s - NUM_DIGITS'(1))) != {NUM_DIGITS{1'b0}}) begin
            multi_s = 1'b1;
        end else begin
            one_hot_s = (an_low_s != {NUM_DIGITS{1'b0}});
        end
        if (commit_s && one_hot_s) begin
            wr_mask_s = an_low_s;
            err_set_s = dec_s.bad;
        end else if (commit_s && multi_s) begin
            err_set_s = 1'b1;
        end else begin
            wr_mask_s = {NUM_DIGITS{1'b0}};
            err_set_s = 1'b0;
        end
    end

    // Capture FSM, slot storage and frame hand-off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_TRACK;
            seen_r       <= {NUM_DIGITS{1'b0}};
            err_r        <= 1'b0;
            slot_blank_r <= {NUM_DIGITS{1'b1}};
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot_val_r[i] <= 4'hF;
            end
            digits_out   <= {(4*NUM_DIGITS){1'b1}};
            blank_out    <= {NUM_DIGITS{1'b1}};
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            case (state_r)
                S_TRACK: state_r <= commit_s ? S_HOLD : S_TRACK;
                S_HOLD:  state_r <= same_s ? S_HOLD : S_TRACK;
                default: state_r <= S_TRACK;
            endcase
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_mask_s[i]) begin
                    slot_val_r[i]   <= dec_s.val;
                    slot_blank_r[i] <= dec_s.blank;
                end
            end
            // A commit landing on the hand-off edge belongs to the new frame
            if (seen_r == {NUM_DIGITS{1'b1}}) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digits_out[4*i +: 4] <= slot_val_r[i];
                end
                blank_out   <= slot_blank_r;
                frame_err   <= err_r;
                frame_valid <= 1'b1;
                seen_r      <= wr_mask_s;
                err_r       <= err_set_s;
            end else begin
                frame_valid <= 1'b0;
                seen_r      <= seen_r | wr_mask_s;
                err_r       <= err_r | err_set_s;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: frame assembly, latency, glitch rejection, errors, reset.
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digits_out;
    logic [3:0]  blank_out;
    logic        frame_valid;
    logic        frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int drv_cyc = 0;
    int fv_cnt = 0;
    int fv_cyc = 0;
    int fv_base = 0;
    logic [15:0] cap_digits = 16'h0000;
    logic [3:0]  cap_blank = 4'h0;
    logic        cap_err = 1'b0;

    seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits_out  (digits_out),
        .blank_out   (blank_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every frame pulse with the outputs it publishes
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_cnt     <= fv_cnt + 1;
            fv_cyc     <= cyc;
            cap_digits <= digits_out;
            cap_blank  <= blank_out;
            cap_err    <= frame_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bus state just after an edge and hold it for n cycles
    task automatic put(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in   = an;
        seg_in  = seg;
        drv_cyc = cyc;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        an_in  = 4'hF;
        seg_in = 7'h7F;
        #2;
        chk("rst_digits", 32'(digits_out), 32'h0000FFFF);
        chk("rst_blank", 32'(blank_out), 32'hF);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Basic scan: digits 3,0,2,7
        fv_base = fv_cnt;
        put(4'b1110, 7'h30, 12);
        put(4'b1101, 7'h40, 12);
        put(4'b1011, 7'h24, 12);
        put(4'b0111, 7'h78, 14);
        chk("scan_fv_count", 32'(fv_cnt - fv_base), 32'd1);
        chk("scan_digits", 32'(cap_digits), 32'h7203);
        chk("scan_blank", 32'(cap_blank), 32'h0);
        chk("scan_err", 32'(cap_err), 32'h0);
        chk("scan_latency", 32'(fv_cyc - drv_cyc), 32'd11);
        chk("scan_fv_low", 32'(frame_valid), 32'h0);

        // Async reset mid-frame discards the partial frame
        fv_base = fv_cnt;
        put(4'b1110, 7'h12, 12);
        put(4'b1101, 7'h79, 12);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_digits", 32'(digits_out), 32'h0000FFFF);
        chk("mid_rst_blank", 32'(blank_out), 32'hF);
        chk("mid_rst_fv", 32'(frame_valid), 32'h0);
        chk("mid_rst_err", 32'(frame_err), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        put(4'b1101, 7'h79, 12);
        put(4'b1011, 7'h24, 12);
        put(4'b0111, 7'h30, 12);
        chk("partial_no_frame", 32'(fv_cnt - fv_base), 32'd0);
        put(4'b1110, 7'h19, 14);
        chk("after_rst_fv", 32'(fv_cnt - fv_base), 32'd1);
        chk("after_rst_digits", 32'(cap_digits), 32'h3214);

        // Glitching bus on slot 0 must never commit
        fv_base = fv_cnt;
        put(4'b1110, 7'h40, 5);
        put(4'b1110, 7'h79, 5);
        put(4'b1110, 7'h24, 5);
        put(4'b1110, 7'h30, 5);
        put(4'b1110, 7'h19, 5);
        put(4'b1110, 7'h12, 5);
        put(4'b1101, 7'h12, 12);
        put(4'b1011, 7'h02, 12);
        put(4'b0111, 7'h00, 12);
        chk("glitch_no_frame", 32'(fv_cnt - fv_base), 32'd0);
        put(4'b1110, 7'h10, 14);
        chk("glitch_then_fv", 32'(fv_cnt - fv_base), 32'd1);
        chk("glitch_digits", 32'(cap_digits), 32'h8659);

        // Blank digit in slot 3
        fv_base = fv_cnt;
        put(4'b1110, 7'h79, 12);
        put(4'b1101, 7'h12, 12);
        put(4'b1011, 7'h10, 12);
        put(4'b0111, 7'h7F, 14);
        chk("blank_fv", 32'(fv_cnt - fv_base), 32'd1);
        chk("blank_digits", 32'(cap_digits), 32'hF951);
        chk("blank_mask", 32'(cap_blank), 32'h8);
        chk("blank_err", 32'(cap_err), 32'h0);

        // Hex letter A on slot 1
        fv_base = fv_cnt;
        put(4'b1110, 7'h00, 12);
        put(4'b1101, 7'h08, 12);
        put(4'b1011, 7'h19, 12);
        put(4'b0111, 7'h02, 14);
        chk("hex_fv", 32'(fv_cnt - fv_base), 32'd1);
        chk("hex_blank", 32'(cap_blank), 32'h0);
`ifdef SEG7_HEX_EN
        chk("hex_digits", 32'(cap_digits), 32'h64A8);
        chk("hex_err", 32'(cap_err), 32'h0);
`else
        chk("hex_digits", 32'(cap_digits), 32'h64F8);
        chk("hex_err", 32'(cap_err), 32'h1);
`endif

        // Two anodes low flags the frame; next clean frame is error-free
        fv_base = fv_cnt;
        put(4'b1100, 7'h40, 12);
        put(4'b1110, 7'h79, 12);
        put(4'b1101, 7'h24, 12);
        put(4'b1011, 7'h30, 12);
        put(4'b0111, 7'h19, 14);
        chk("multi_fv", 32'(fv_cnt - fv_base), 32'd1);
        chk("multi_digits", 32'(cap_digits), 32'h4321);
        chk("multi_err", 32'(cap_err), 32'h1);
        chk("multi_err_held", 32'(frame_err), 32'h1);
        put(4'b1110, 7'h12, 12);
        put(4'b1101, 7'h02, 12);
        put(4'b1011, 7'h78, 12);
        put(4'b0111, 7'h00, 14);
        chk("clean_fv", 32'(fv_cnt - fv_base), 32'd2);
        chk("clean_digits", 32'(cap_digits), 32'h8765);
        chk("clean_err", 32'(cap_err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
